queue_reader: RTL and testbench

//  Read-side consumer for the hardware queue. Pulls entries with a one-cycle

---
 rtl/queue_pkg.sv | 14 +
 rtl/queue_out_reg.sv | 30 +++
 rtl/queue_reader.sv | 82 ++++++++
 tb/tb_queue_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared constants for the queue read-side blocks: default geometry, the
// fixed read latency, and the width helper for the packing counter.
package queue_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int PACK_DEF   = 2;
    // Data appears on q_dout exactly this many cycles after q_rd; this is fixed.
    localparam int RD_LAT     = 1;

    function automatic int cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/queue_out_reg.sv
// Output holding register. A word is held stable while m_valid=1 and leaves
// on any edge where m_valid && m_ready; a load may replace it on that edge.
module queue_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         m_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic         free
);

    assign free = !m_valid || m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= din;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/queue_reader.sv
// Drain-side queue consumer: strobes entries out of the queue, packs PACK of
// them (first entry in the MSBs) and hands the word to queue_out_reg.
module queue_reader
    import queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PACK   = PACK_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   q_empty,
    input  logic [DATA_W-1:0]      q_dout,
    output logic                   q_rd,
    input  logic                   flush,
    output logic                   m_valid,
    output logic [DATA_W*PACK-1:0] m_data,
    input  logic                   m_ready,
    output logic                   busy
);

    localparam int               CNT_W    = cnt_w(PACK);
    localparam int               WORD_W   = DATA_W * PACK;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);

    // Handshake: m_data is transferred on every rising edge where
    // m_valid && m_ready; m_valid never drops and m_data never changes
    // while waiting for m_ready.

    logic [CNT_W-1:0]  cnt;
    logic              inflight;
    logic [WORD_W-1:0] asm_data;
    logic              out_free;
    logic              full;
    logic              xfer;
    logic              capture;

    always_comb begin
        full    = (cnt == CNT_FULL);
        xfer    = full && out_free;
        capture = inflight && !flush;
        // Entries already in the assembly reg plus the one in flight must
        // leave room, so a held output word stalls reads at the queue.
        q_rd    = reset && !q_empty && !flush &&
                  ((int'(cnt) + int'(inflight)) < PACK);
        busy    = (cnt != '0) || inflight || m_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            inflight <= 1'b0;
            asm_data <= '0;
        end else begin
            inflight <= q_rd;
            // cnt+inflight never exceeds PACK, so capture and xfer are exclusive.
            if (xfer || flush) begin
                cnt <= '0;
            end else if (capture) begin
                cnt <= cnt + CNT_W'(1);
            end
            for (int i = 0; i < PACK; i++) begin
                if (capture && int'(cnt) == i) begin
                    asm_data[(PACK-1-i)*DATA_W +: DATA_W] <= q_dout;
                end
            end
        end
    end

    queue_out_reg #(
        .W(WORD_W)
    ) u_out (
        .clk     (clk),
        .reset   (reset),
        .load    (xfer),
        .din     (asm_data),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .free    (out_free)
    );

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: PACK=2 and PACK=1 instances, each fed by a small
// queue model; delivered words are matched against an expected queue.
module tb_queue_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic flush;

    // PACK=2 instance
    logic       q_empty;
    logic [3:0] q_dout;
    logic       q_rd;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       busy;
    logic [3:0] qmem[$];
    logic [7:0] exp_q[$];
    int         rd_count;

    // PACK=1 instance
    logic       q_empty1;
    logic [3:0] q_dout1;
    logic       q_rd1;
    logic       m_valid1;
    logic [3:0] m_data1;
    logic       m_ready1;
    logic       busy1;
    logic [3:0] qmem1[$];
    logic [3:0] exp1_q[$];

    int checks = 0;
    int errors = 0;

    queue_reader #(.DATA_W(4), .PACK(2)) dut (
        .clk(clk), .reset(reset), .q_empty(q_empty), .q_dout(q_dout),
        .q_rd(q_rd), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy)
    );

    queue_reader #(.DATA_W(4), .PACK(1)) dut1 (
        .clk(clk), .reset(reset), .q_empty(q_empty1), .q_dout(q_dout1),
        .q_rd(q_rd1), .flush(flush), .m_valid(m_valid1), .m_data(m_data1),
        .m_ready(m_ready1), .busy(busy1)
    );

    // Queue models: one-cycle read latency, empty updates after the read edge.
    always @(posedge clk) begin
        if (q_rd && qmem.size() != 0) begin
            q_dout  <= qmem.pop_front();
            q_empty <= (qmem.size() == 0);
            rd_count++;
        end
        if (q_rd1 && qmem1.size() != 0) begin
            q_dout1  <= qmem1.pop_front();
            q_empty1 <= (qmem1.size() == 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        logic [3:0] e1;
        if (reset && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected got %h", m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL word got %h want %h", m_data, e);
                end
            end
        end
        if (reset && m_valid1 && m_ready1) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL word1_unexpected got %h", m_data1);
            end else begin
                e1 = exp1_q.pop_front();
                if (m_data1 !== e1) begin
                    errors++;
                    $display("FAIL word1 got %h want %h", m_data1, e1);
                end
            end
        end
        if (q_empty) begin
            checks++;
            if (q_rd !== 1'b0) begin
                errors++;
                $display("FAIL rd_on_empty got %b want 0", q_rd);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push n nibbles (first entry in the most significant used nibble).
    task automatic push_n(input int n, input logic [23:0] vals);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) qmem.push_back(vals[4*(n-1-i) +: 4]);
        q_empty = 1'b0;
    endtask

    task automatic push1_n(input int n, input logic [23:0] vals);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) qmem1.push_back(vals[4*(n-1-i) +: 4]);
        q_empty1 = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0 || busy || busy1) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout got %0d cycles want < %0d", name, n, budget);
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b0; flush = 1'b0; m_ready = 1'b0; m_ready1 = 1'b0;
        q_empty = 1'b1; q_dout = '0; q_empty1 = 1'b1; q_dout1 = '0;
        rd_count = 0;
        #2;
        check("rst_q_rd", 32'(q_rd), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_m_valid1", 32'(m_valid1), 0);

        // 1: entries queued during reset are read only after release
        exp_q.push_back(8'hAC);
        push_n(2, 24'h00_00AC);
        tick(2);
        check("t1_rd_in_reset", 32'(q_rd), 0);
        check("t1_no_reads", 32'(rd_count), 0);
        reset = 1'b1;
        m_ready = 1'b1;
        wait_drain("t1", 30);
        check("t1_reads", 32'(rd_count), 2);
        check("t1_m_valid", 32'(m_valid), 0);
        check("t1_busy", 32'(busy), 0);

        // 2: two words streamed
        rd_count = 0;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        push_n(4, 24'h00_1234);
        wait_drain("t2", 40);
        check("t2_reads", 32'(rd_count), 4);

        // 3: backpressure stops reads after the assembly reg fills
        m_ready = 1'b0;
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h9A);
        push_n(6, 24'h56789A);
        tick(15);
        check("t3_held_valid", 32'(m_valid), 1);
        check("t3_held_data", 32'(m_data), 32'h56);
        check("t3_rd_stalled", 32'(q_rd), 0);
        check("t3_queue_left", 32'(qmem.size()), 2);
        m_ready = 1'b1;
        wait_drain("t3", 40);
        check("t3_queue_empty", 32'(qmem.size()), 0);

        // 4: partial word flushed
        push_n(1, 24'h00000B);
        tick(6);
        check("t4_busy_partial", 32'(busy), 1);
        check("t4_no_valid", 32'(m_valid), 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_busy_flushed", 32'(busy), 0);
        exp_q.push_back(8'hDE);
        push_n(2, 24'h0000DE);
        wait_drain("t4", 30);

        // 5: async reset mid-operation
        m_ready = 1'b0;
        push_n(3, 24'h000123);
        tick(15);
        check("t5_held_data", 32'(m_data), 32'h12);
        check("t5_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(m_valid), 0);
        check("t5_rst_data", 32'(m_data), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_rd", 32'(q_rd), 0);
        tick(2);
        reset = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(8'h45);
        push_n(2, 24'h000045);
        wait_drain("t5", 30);

        // 6: PACK=1 passes each entry through as a word
        m_ready1 = 1'b1;
        exp1_q.push_back(4'hF);
        exp1_q.push_back(4'h0);
        push1_n(2, 24'h0000F0);
        wait_drain("t6", 30);

        check("end_exp_q", 32'(exp_q.size()), 0);
        check("end_exp1_q", 32'(exp1_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
